// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and alignment check for the data-memory access controller.
// Pure declarations; no timing or flow-control behaviour lives here.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WRITE,
        ST_RESP
    } state_t;

    // A request errors when it is misaligned for its size or uses the reserved size code.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = offset[0];
            SIZE_WORD: err = (offset != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: merges store data into a RAM word and extracts/extends load lanes.
// Purely combinational, zero latency; no flow control.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        merged    = word;
        extracted = word;
        case (size)
            SIZE_BYTE: begin
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
                extracted = {{24{sign_ext & lane_b[7]}}, lane_b};
            end
            SIZE_HALF: begin
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
                extracted = {{16{sign_ext & lane_h[15]}}, lane_h};
            end
            default: begin
                merged    = wdata;
                extracted = word;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Byte/half/word load-store front end for a word RAM; 1/2/3/4 cycles for error/word store/load/sub-word store.
// One request in flight; req_ready only in IDLE, responses are a single-cycle pulse with no backpressure.
module data_mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_signed,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_data,
    output logic                      ram_we,
    input  logic [DATA_WIDTH-1:0]     ram_q
);

    state_t                    state, state_nxt;
    logic [MEM_ADDR_WIDTH+1:0] addr_q;
    logic [1:0]                size_q;
    logic                      signed_q;
    logic                      we_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH-1:0]     wr_word_q;
    logic                      err_q;
    logic                      accept;
    logic                      req_err;
    logic [DATA_WIDTH-1:0]     merged;
    logic [DATA_WIDTH-1:0]     extracted;
    logic                      unused_addr_hi;

    // Upper address bits fall outside the RAM, so accesses wrap modulo its depth.
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    assign accept   = req_valid && req_ready;
    assign req_err  = access_err(req_size, req_addr[1:0]);
    assign ram_addr = addr_q[MEM_ADDR_WIDTH+1:2];
    assign ram_data = wr_word_q;
    assign rsp_err  = err_q;
    assign rsp_rdata = rdata_q;

    mem_byte_lane u_lane (
        .word      (ram_q),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .sign_ext  (signed_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                              state_nxt = ST_RESP;
                    else if (req_we && req_size == SIZE_WORD) state_nxt = ST_WRITE;
                    else                                      state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_nxt = ST_RD_DATA;
            ST_RD_DATA: state_nxt = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE:   state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        case (state)
            ST_IDLE:  req_ready = 1'b1;
            ST_WRITE: ram_we    = 1'b1;
            ST_RESP:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    // Load data is cleared at acceptance so stores and errors respond with zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_word_q <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            addr_q    <= req_addr[MEM_ADDR_WIDTH+1:0];
            size_q    <= req_size;
            signed_q  <= req_signed;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            wr_word_q <= req_wdata;
            err_q     <= req_err;
        end else if (state == ST_RD_DATA) begin
            if (we_q) wr_word_q <= merged;
            else      rdata_q   <= extracted;
        end
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Randomised scoreboard bench for data_mem_access_ctrl with a byte-addressed reference memory.
module tb_data_mem_access_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic [31:0] ram_q;

    logic [31:0] mem [256];
    logic [7:0]  ref_bytes [1024];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          wr_total = 0;
    int          wr_base = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    data_mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
            wr_total <= wr_total + 1;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    // Reference behaviour: little-endian byte memory, alignment by modulo, extension by masking.
    task automatic ref_op(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          nb;
        int          a;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a  = int'(addr % 1024);
        e.acc = cyc;
        e.nwr = 0;
        e.rdata = '0;
        e.err = 1'b0;
        if (size == 2'd3 || (addr % nb) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (we) begin
            for (int b = 0; b < nb; b++) ref_bytes[a+b] = wd[8*b +: 8];
            e.lat = (nb == 4) ? 2 : 4;
            e.nwr = 1;
        end else begin
            v = '0;
            for (int b = 0; b < nb; b++) v = v | (32'(ref_bytes[a+b]) << (8*b));
            if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            e.rdata = v;
            e.lat = 3;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 30) begin
            req_valid  = 1'b1;
            req_we     = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
            req_valid = 1'b0;
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        ref_op(we, size, sgn, addr, wd);
        @(posedge clk);
        #1;
        req_valid = hold;
        chk("ready_busy", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            exp_t e;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got err=%b rdata=%h, expected no response", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("ram_writes", 32'(wr_total - wr_base), 32'(e.nwr));
                chk("ready_in_resp", {31'b0, req_ready}, 32'd0);
            end
            wr_base = wr_total;
        end
    end

    initial begin
        logic [31:0] w0, w1;
        logic [7:0]  saved [4];
        int          wt;
        bit          hold;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = mem[i][8*b +: 8];
        end

        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_ram_data", ram_data, 32'd0);
        chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Word store then word load.
        issue(1, 2'd2, 0, 32'h08, 32'h12345678, 0);
        wait_done();
        chk("t1_mem2", mem[2], 32'h12345678);
        issue(0, 2'd2, 0, 32'h08, 32'h0, 0);
        wait_done();
        chk("t1_load", last_rdata, 32'h12345678);

        // Byte store and sign/zero-extended byte loads.
        issue(1, 2'd0, 0, 32'h09, 32'hFFFFFFAB, 0);
        wait_done();
        chk("t2_mem2", mem[2], 32'h1234AB78);
        issue(0, 2'd0, 1, 32'h09, 32'h0, 0);
        wait_done();
        chk("t2_lb_signed", last_rdata, 32'hFFFFFFAB);
        issue(0, 2'd0, 0, 32'h09, 32'h0, 0);
        wait_done();
        chk("t2_lb_unsigned", last_rdata, 32'h000000AB);

        // Half store and halfword loads.
        issue(1, 2'd1, 0, 32'h0A, 32'h1234BEEF, 0);
        wait_done();
        chk("t3_mem2", mem[2], 32'hBEEFAB78);
        issue(0, 2'd1, 1, 32'h0A, 32'h0, 0);
        wait_done();
        chk("t3_lh_signed", last_rdata, 32'hFFFFBEEF);
        issue(0, 2'd1, 0, 32'h0A, 32'h0, 0);
        wait_done();
        chk("t3_lh_unsigned", last_rdata, 32'h0000BEEF);

        // Misaligned and reserved-size requests.
        w0 = mem[0];
        w1 = mem[1];
        wt = wr_total;
        issue(0, 2'd2, 0, 32'h06, 32'h0, 0);
        issue(1, 2'd1, 0, 32'h03, 32'hDEADBEEF, 0);
        issue(1, 2'd3, 1, 32'h04, 32'hCAFEF00D, 0);
        wait_done();
        chk("t4_last_err", {31'b0, last_err}, 32'd1);
        chk("t4_no_write", 32'(wr_total - wt), 32'd0);
        chk("t4_mem0", mem[0], w0);
        chk("t4_mem1", mem[1], w1);

        // Asynchronous reset in RD_DATA of a byte store.
        for (int b = 0; b < 4; b++) saved[b] = ref_bytes[8+b];
        wt = wr_total;
        issue(1, 2'd0, 0, 32'h08, 32'h00000055, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_req_ready", {31'b0, req_ready}, 32'd1);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t5_rsp_rdata", rsp_rdata, 32'd0);
        chk("t5_ram_we", {31'b0, ram_we}, 32'd0);
        chk("t5_ram_data", ram_data, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_write", 32'(wr_total - wt), 32'd0);
        chk("t5_mem2", mem[2], 32'hBEEFAB78);
        void'(exp_q.pop_back());
        for (int b = 0; b < 4; b++) ref_bytes[8+b] = saved[b];
        reset = 1'b1;
        issue(0, 2'd2, 0, 32'h08, 32'h0, 0);
        wait_done();
        chk("t5_load_old", last_rdata, 32'hBEEFAB78);

        // Back-to-back requests with req_valid held high.
        issue(1, 2'd2, 0, 32'h10, 32'hA0A0A0A0, 1);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        wait_done();
        chk("t6_mem4", mem[4], 32'hA0A0A0A0);
        chk("t6_load", last_rdata, 32'hA0A0A0A0);

        // Random traffic, including wrapped upper address bits.
        for (int i = 0; i < 400; i++) begin
            hold = (i < 399) ? 1'($urandom) : 1'b0;
            issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'hFFFF_FC3F, $urandom, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_done();

        for (int i = 0; i < 256; i++) chk("ram_final", mem[i], ref_word(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_access_ctrl.md
# data_mem_access_ctrl

Load/store access controller that sits directly upstream of the word-wide `single_port_ram` data memory. It accepts byte, halfword and word requests on byte addresses from the datapath. It translates them into word-addressed RAM reads and writes, using read-modify-write for sub-word stores. It returns load data extracted from the correct byte lane, sign- or zero-extended.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the request byte address.
- `DATA_WIDTH`, 32: data width. Fixed at 32; any other value is unsupported.
- `MEM_ADDR_WIDTH`, 8: width of the RAM word address. Depth is 2^MEM_ADDR_WIDTH words.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request. High only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size. 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1: sign-extend sub-word loads.
- `req_addr`  in  ADDR_WIDTH: byte address.
- `req_wdata`  in  DATA_WIDTH: store data, right-aligned.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: request was misaligned or had a reserved size. Valid with `rsp_valid`.
- `rsp_rdata`  out  DATA_WIDTH: load result. Valid with `rsp_valid`. 0 for stores and errors.
- `ram_addr`  out  MEM_ADDR_WIDTH: equals `addr_q[MEM_ADDR_WIDTH+1:2]`.
- `ram_data`  out  DATA_WIDTH: RAM write data.
- `ram_we`  out  1: RAM write enable.
- `ram_q`  in  DATA_WIDTH: RAM read data, valid one cycle after the address is sampled.

## Operation
- A request is accepted on a rising edge with `req_valid && req_ready`. On acceptance, addr, size, signed, we and wdata are latched.
- Byte lanes are little-endian:
  - A byte at `addr[1:0]=k` occupies bits `8k+7:8k`.
  - A half at `addr[1]=h` occupies bits `16h+15:16h`.
- Error check at acceptance: half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11.
  - An erroring request makes no RAM access and goes IDLE→RESP with `rsp_err=1`.
- Address bits above `MEM_ADDR_WIDTH+1` are ignored, so addresses wrap modulo the RAM depth.
- FSM transitions:
  - IDLE: word store → WRITE; error → RESP; otherwise → RD_WAIT.
  - RD_WAIT: drives `ram_addr` with `ram_we=0`; the RAM samples the address. → RD_DATA.
  - RD_DATA: `ram_q` is valid.
    - Load: extract and extend the lane into `rsp_rdata`, then → RESP.
    - Sub-word store: merge the low bits of `wdata` into the addressed lane of `ram_q`, then → WRITE.
  - WRITE: `ram_we=1`, `ram_data` = word or merged word. → RESP.
  - RESP: `rsp_valid=1` for exactly one cycle. → IDLE.
- Extension: when `req_signed=1`, the lane MSB is replicated. When 0, the result is zero-filled. A word load ignores `req_signed`.
- Responses have no backpressure. The datapath must accept the `rsp_valid` pulse.

## Timing
- Latency from the acceptance edge to the `rsp_valid` cycle:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- `req_ready` is combinational from state (high in IDLE only).
- A new request can be accepted in the cycle after RESP, i.e. in IDLE.
- `ram_we` is combinational from state, so it is high only in WRITE. Exactly one RAM write occurs per store.
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `ram_we=0`, `ram_data=0`, latched request registers 0.
- Reset asserted mid-operation:
  - The operation is aborted immediately and asynchronously.
  - No RAM write is issued after reset is asserted.
  - No response is produced for the aborted request.
- `req_valid` is ignored outside IDLE, and request inputs may change freely then.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`
  - the FSM state enum
  - the error-check function
- Sub-module `mem_byte_lane` (combinational) contains the store-merge and load-extract/extend logic. It takes the word, lane offset, size, signed flag and wdata.
- The top level holds the FSM and the request/response registers.

## Test plan
1. Word store 0x12345678 to address 0x08, then word load from 0x08:
   - The RAM word at index 2 becomes 0x12345678.
   - Load returns `rsp_rdata`=0x12345678 with `rsp_err=0`.
   - Latencies are exactly 2 cycles (store) and 3 cycles (load).
2. Byte store 0xAB to 0x09 over 0x12345678, then byte loads from 0x09:
   - The RAM word becomes 0x1234AB78.
   - Signed byte load returns 0xFFFFFFAB.
   - Unsigned byte load returns 0x000000AB.
   - Store latency is 4 cycles, with one `ram_we` pulse.
3. Half store 0xBEEF to 0x0A, then halfword loads from 0x0A:
   - The RAM word becomes 0xBEEFAB78.
   - Signed load returns 0xFFFFBEEF.
   - Unsigned load returns 0x0000BEEF.
4. Word load from 0x06, half store to 0x03, and a size-11 request:
   - Each gives `rsp_err=1` and `rsp_rdata=0` one cycle after acceptance.
   - `ram_we` never asserts and RAM contents are unchanged.
5. Assert `reset` low during RD_DATA of a byte store to 0x08:
   - Outputs go to reset values immediately.
   - `ram_we` never asserts and the word at 0x08 is unchanged.
   - After reset release, a word load from 0x08 returns the old value.
6. Hold `req_valid` high with two queued requests (store 0xA0A0A0A0 to 0x10, then load from 0x10):
   - `req_ready` is high only in IDLE.
   - Both requests are accepted in order.
   - The load returns 0xA0A0A0A0.
